cbus_arbiter: RTL

Round-robin arbiter that merges the cache-side bus requests of several masters (instruction cache on port 0, data cache on port 1) onto the single cbus toward the memory/AXI bridge. It sits directly downstream of the data cache, carrying its line refills, dirty-line write-backs and uncached single-beat accesses. A port is granted for one whole transaction, whether a burst or a single beat, and keeps the grant until the final beat completes.

---
 rtl/cbus_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging per-master cbus requests onto one memory-side cbus.
// A grant covers a whole transaction and is released only on the final ready&&last beat.
package cbus_pkg;
    // len encodes beats-1, so a transaction carries len+1 beats
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic {
        FIXED = 1'b0,
        INCR  = 1'b1
    } burst_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        burst_t      burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output arb_state_t       o_dbg_state,
    output logic [IDX_W-1:0] o_dbg_sel
);

    // Handshake: a master raises valid and holds it until its transaction ends; each
    // cycle with ready=1 is one accepted beat, and ready&&last marks the final beat.

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] r_prev;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Scan prev+1, prev+2, ... with wrap; the first valid port wins
    always_comb begin : rr_scan
        w_found = 1'b0;
        w_pick  = r_prev;
        w_cand  = r_prev;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_prev) + k) % NUM_REQ);
            if (!w_found && ireqs[w_cand].valid) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin : fsm_out
        w_next_state = r_state;
        oreq         = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            iresps[j] = '0;
        end
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // oreq depends only on ireqs and r_sel, never on oresp
                oreq          = ireqs[r_sel];
                iresps[r_sel] = oresp;
                if (oresp.ready && oresp.last) begin
                    w_next_state = ARB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
            r_sel   <= '0;
            r_prev  <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_next_state;
            if (r_state == ARB_IDLE && w_found) begin
                r_sel  <= w_pick;
                r_prev <= w_pick;
            end
        end
    end

    assign o_dbg_state = r_state;
    assign o_dbg_sel   = r_sel;

endmodule
